// File: rtl/l2_ram_multi_bank_pipe_if.sv
// L2 multi-bank RAM port bundle: one TCDM slave port per bank,
// flattened P-wide request and response vectors.
interface l2_ram_multi_bank_pipe_if #(
    parameter int unsigned P = 6
);
    logic [P-1:0]    req;
    logic [P*32-1:0] add;
    logic [P-1:0]    wen;
    logic [P*32-1:0] wdata;
    logic [P*4-1:0]  be;
    logic [P-1:0]    gnt;
    logic [P-1:0]    r_valid;
    logic [P*32-1:0] r_rdata;
    logic [P-1:0]    r_opc;

    modport master (
        output req, add, wen, wdata, be,
        input  gnt, r_valid, r_rdata, r_opc
    );
    modport slave (
        input  req, add, wen, wdata, be,
        output gnt, r_valid, r_rdata, r_opc
    );
endinterface

// File: rtl/l2_ram_multi_bank_pipe.sv
// L2 SoC memory: interleaved + private banks with configurable read
// latency, out-of-range error response and a zero-init engine.
module l2_ram_multi_bank_pipe #(
    parameter int unsigned NB_BANKS      = 4,
    parameter int unsigned NB_PRI        = 2,
    parameter int unsigned INTL_WORDS    = 32768,
    parameter int unsigned PRI_WORDS     = 8192,
    parameter logic [31:0] INTL_BASE     = 32'h1C01_0000,
    parameter logic [31:0] PRI_BASE      = 32'h1C00_0000,
    parameter int unsigned LATENCY       = 1,
    parameter bit          INIT_ON_RESET = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic init_req_i,
    output logic init_done_o,
    l2_ram_multi_bank_pipe_if.slave bus
);
    localparam int unsigned P    = NB_BANKS + NB_PRI;
    localparam int unsigned MAXW =
        (INTL_WORDS > PRI_WORDS) ? INTL_WORDS : PRI_WORDS;
    localparam int unsigned CW   = $clog2(MAXW);

    typedef enum logic [1:0] {IDLE, INIT, DONE} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            boot_q, boot_d;
    logic            busy;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        boot_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (init_req_i || (INIT_ON_RESET && boot_q)) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end
            end
            INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(MAXW - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end
            end
            DONE: begin
                if (init_req_i) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            boot_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            boot_q  <= boot_d;
        end
    end

    assign busy        = (state_q == INIT);
    assign init_done_o = (state_q == DONE);

    for (genvar i = 0; i < P; i++) begin : g_port
        localparam bit PRI = (i >= NB_BANKS);
        localparam int unsigned WORDS = PRI ? PRI_WORDS : INTL_WORDS;
        localparam int unsigned RW    = $clog2(WORDS);
        localparam int unsigned SH    =
            PRI ? 2 : 2 + $clog2(NB_BANKS);
        localparam int unsigned PIDX  = PRI ? i - NB_BANKS : 0;
        localparam logic [31:0] BASE  =
            PRI ? PRI_BASE + 32'(PIDX * PRI_WORDS * 4) : INTL_BASE;
        localparam logic [32:0] SIZE  = PRI ?
            33'(PRI_WORDS) * 33'd4 :
            33'(NB_BANKS) * 33'(INTL_WORDS) * 33'd4;

        logic [31:0]        mem [WORDS];
        logic [31:0]        off, wdat;
        logic [RW-1:0]      row, wrow;
        logic               gnt, in_rng, rd_en, we;
        logic [3:0]         wbe;
        logic [LATENCY-1:0] vld_q, vld_d, opc_q, opc_d;
        logic [LATENCY-1:0] rsel_q, rsel_d;
        logic [31:0]        dat_q [LATENCY];
        logic [31:0]        dat_d [LATENCY];

        // Init owns the SRAM port; rows beyond this bank are skipped.
        always_comb begin
            off    = bus.add[i*32 +: 32] - BASE;
            row    = off[SH +: RW];
            in_rng = ({1'b0, off} < SIZE);
            gnt    = bus.req[i] & ~busy & ~rst_i;
            rd_en  = gnt & bus.wen[i] & in_rng;
            we     = busy ? (32'(cnt_q) < WORDS)
                          : (gnt & ~bus.wen[i] & in_rng);
            wrow   = busy ? cnt_q[RW-1:0] : row;
            wdat   = busy ? 32'h0 : bus.wdata[i*32 +: 32];
            wbe    = busy ? 4'hF : bus.be[i*4 +: 4];
        end

        always_ff @(posedge clk_i) begin
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (wbe[b]) mem[wrow][b*8 +: 8] <= wdat[b*8 +: 8];
                end
            end
        end

        always_comb begin
            vld_d[0]  = gnt;
            opc_d[0]  = gnt & ~in_rng;
            rsel_d[0] = rd_en;
            dat_d[0]  = rd_en ? mem[row] : dat_q[0];
            for (int s = 1; s < LATENCY; s++) begin
                vld_d[s]  = vld_q[s-1];
                opc_d[s]  = opc_q[s-1];
                rsel_d[s] = rsel_q[s-1];
                dat_d[s]  = dat_q[s-1];
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                vld_q  <= '0;
                opc_q  <= '0;
                rsel_q <= '0;
                for (int s = 0; s < LATENCY; s++) dat_q[s] <= '0;
            end else begin
                vld_q  <= vld_d;
                opc_q  <= opc_d;
                rsel_q <= rsel_d;
                for (int s = 0; s < LATENCY; s++) dat_q[s] <= dat_d[s];
            end
        end

        assign bus.gnt[i]            = gnt;
        assign bus.r_valid[i]        = vld_q[LATENCY-1];
        assign bus.r_opc[i]          = opc_q[LATENCY-1];
        assign bus.r_rdata[i*32 +: 32] =
            rsel_q[LATENCY-1] ? dat_q[LATENCY-1] : 32'h0;
    end
endmodule
